// File: rtl/line_rotator_param_if.sv
// Stream, control and status bundle for line_rotator_param.
// The master side drives the video stream and per-line controls; the slave side is the rotator.
interface line_rotator_param_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CUT_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic              H;
    logic              V;
    logic [CUT_W-1:0]  raw_cut_position;
    logic              descramble;
    logic              enable;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              line_err;

    modport master (
        output data_in, H, V, raw_cut_position, descramble, enable,
        input  data_out, data_valid, line_err
    );

    modport slave (
        input  data_in, H, V, raw_cut_position, descramble, enable,
        output data_out, data_valid, line_err
    );
endinterface

// File: rtl/line_rotator_param.sv
// Line-rotation scrambler/descrambler: each active line is captured in a ping-pong buffer and
// replayed during the next line starting at a per-line cut index; blanking passes through.
module line_rotator_param #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned ACTIVE_WORDS = 1440,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned CUT_W        = 8,
    parameter int unsigned CUT_STEP     = 4
) (
    input logic                clk,
    input logic                reset_n,
    line_rotator_param_if.slave bus
);
    localparam int unsigned      PROD_W   = CUT_W + $clog2(CUT_STEP);
    localparam logic [ADDR_W:0]  LINE_LEN = (ADDR_W + 1)'(ACTIVE_WORDS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ACTIVE_WORDS - 1);

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    logic              sel_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [ADDR_W-1:0] cut_lat_q;
    logic              mode_lat_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic              prev_h_q;
    logic              h_known_q;
    logic              armed_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              line_err_q;

    logic              active;
    logic              eol;
    logic              h_fall;
    logic              wr_en;
    logic [PROD_W-1:0] prod;
    logic [ADDR_W-1:0] cut_d;
    logic [ADDR_W-1:0] start_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] rd_next;

    // h_known_q masks edge detection on the first cycle after reset, when prev_h_q is not real.
    always_comb begin
        active = ~bus.H & ~bus.V;
        eol    = h_known_q & ~prev_h_q & bus.H & ~bus.V;
        h_fall = h_known_q & prev_h_q & ~bus.H;
        wr_en  = active & (wr_cnt_q < LINE_LEN);
    end

    always_comb begin
        prod  = PROD_W'(bus.raw_cut_position) * PROD_W'(CUT_STEP);
        cut_d = '0;
        if (bus.enable) begin
            if (32'(prod) > ACTIVE_WORDS - 1) begin
                cut_d = LAST_IDX;
            end else begin
                cut_d = ADDR_W'(prod);
            end
        end
    end

    // The read index starts at the latched offset and then walks with a compare-and-wrap.
    always_comb begin
        start_idx = cut_lat_q;
        if (mode_lat_q) begin
            start_idx = (cut_lat_q == '0) ? '0 : ADDR_W'(ACTIVE_WORDS) - cut_lat_q;
        end
        rd_idx  = (wr_cnt_q == '0) ? start_idx : rd_ptr_q;
        rd_next = (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{sel_q, wr_cnt_q[ADDR_W-1:0]}] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q        <= 1'b0;
            wr_cnt_q     <= '0;
            cut_lat_q    <= '0;
            mode_lat_q   <= 1'b0;
            rd_ptr_q     <= '0;
            prev_h_q     <= 1'b0;
            h_known_q    <= 1'b0;
            armed_q      <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            prev_h_q   <= bus.H;
            h_known_q  <= 1'b1;
            data_out_q <= active ? mem[{~sel_q, rd_idx}] : bus.data_in;
            line_err_q <= eol & (wr_cnt_q != LINE_LEN);
            if (h_fall) begin
                armed_q <= 1'b1;
            end
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                rd_ptr_q <= rd_next;
            end
            if (eol) begin
                cut_lat_q  <= cut_d;
                mode_lat_q <= bus.descramble;
                sel_q      <= ~sel_q;
                wr_cnt_q   <= '0;
                // Only a line whose start was seen since reset counts as complete.
                if (armed_q) begin
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.line_err   = line_err_q;
endmodule

// File: tb/tb_line_rotator_param.sv
// Directed bench for line_rotator_param with a 16-word line, CUT_STEP=4.
module tb_line_rotator_param;
    localparam int unsigned DW = 10;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    line_rotator_param_if #(.DATA_W(DW), .CUT_W(CW)) bus ();

    line_rotator_param #(
        .DATA_W(DW), .ACTIVE_WORDS(AW), .ADDR_W(4), .CUT_W(CW), .CUT_STEP(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int base;
        int prev;
        int start;
        int raw;
        bit desc;
        bit en;
    } row_t;

    // Each row: line data base, previous line base, expected start index, controls for its EOL.
    row_t rows [7] = '{
        '{100,   0, 12,   3, 1'b0, 1'b1},
        '{200, 100, 12,   5, 1'b1, 1'b0},
        '{300, 200,  0,   0, 1'b1, 1'b1},
        '{400, 300,  0, 255, 1'b1, 1'b1},
        '{500, 400,  1, 255, 1'b0, 1'b1},
        '{600, 500, 15,   1, 1'b1, 1'b1},
        '{700, 600, 12,   2, 1'b0, 1'b1}
    };

    task automatic cycle(input logic [DW-1:0] d, input logic h, input logic v);
        bus.data_in = d;
        bus.H = h;
        bus.V = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            bus.raw_cut_position = CW'($urandom);
            bus.descramble = 1'($urandom);
            bus.enable = 1'($urandom);
            cycle(DW'($urandom), 1'($urandom), 1'($urandom));
            checks += 3;
            if (bus.data_out !== '0) begin
                errors++; $display("FAIL reset data_out: got %0d expected 0", bus.data_out);
            end
            if (bus.data_valid !== 1'b0) begin
                errors++; $display("FAIL reset data_valid: got %0b expected 0", bus.data_valid);
            end
            if (bus.line_err !== 1'b0) begin
                errors++; $display("FAIL reset line_err: got %0b expected 0", bus.line_err);
            end
        end
        bus.raw_cut_position = 3;
        bus.descramble = 1'b0;
        bus.enable = 1'b1;
        bus.H = 1'b1;
        bus.V = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_blank_passthrough();
        logic [DW-1:0] words [6] = '{10'h3FF, 10'h000, 10'h000, 10'h2D8, 10'h200, 10'h040};
        for (int i = 0; i < 6; i++) begin
            cycle(words[i], 1'b1, 1'b0);
            checks += 2;
            if (bus.data_out !== words[i]) begin
                errors++;
                $display("FAIL blank passthrough %0d: got %0d expected %0d", i, bus.data_out, words[i]);
            end
            if (bus.line_err !== 1'b0) begin
                errors++; $display("FAIL blank line_err: got %0b expected 0", bus.line_err);
            end
        end
    endtask

    task automatic test_first_line();
        for (int k = 0; k < AW; k++) cycle(DW'(k), 1'b0, 1'b0);
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL first line valid early: got %0b expected 0", bus.data_valid);
        end
        cycle(10'h3FF, 1'b1, 1'b0);
        checks += 2;
        if (bus.data_valid !== 1'b1) begin
            errors++; $display("FAIL first eol data_valid: got %0b expected 1", bus.data_valid);
        end
        if (bus.line_err !== 1'b0) begin
            errors++; $display("FAIL first eol line_err: got %0b expected 0", bus.line_err);
        end
        cycle(10'h200, 1'b1, 1'b0);
    endtask

    // Rotation table; controls are scrambled mid-line to show they only matter at EOL.
    task automatic test_rotations();
        logic [DW-1:0] exp;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < AW; k++) begin
                if (k == 8) begin
                    bus.raw_cut_position = CW'($urandom);
                    bus.descramble = 1'($urandom);
                    bus.enable = 1'($urandom);
                end
                cycle(DW'(rows[r].base + k), 1'b0, 1'b0);
                exp = DW'(rows[r].prev + (rows[r].start + k) % AW);
                checks++;
                if (bus.data_out !== exp) begin
                    errors++;
                    $display("FAIL rotation row %0d word %0d: got %0d expected %0d",
                             r, k, bus.data_out, exp);
                end
            end
            bus.raw_cut_position = CW'(rows[r].raw);
            bus.descramble = rows[r].desc;
            bus.enable = rows[r].en;
            cycle(10'h3FF, 1'b1, 1'b0);
            checks += 3;
            if (bus.data_out !== 10'h3FF) begin
                errors++; $display("FAIL rotation eol word row %0d: got %0d expected 1023", r, bus.data_out);
            end
            if (bus.line_err !== 1'b0) begin
                errors++; $display("FAIL rotation line_err row %0d: got %0b expected 0", r, bus.line_err);
            end
            if (bus.data_valid !== 1'b1) begin
                errors++; $display("FAIL rotation data_valid row %0d: got %0b expected 1", r, bus.data_valid);
            end
            cycle(DW'(10'h200 + r), 1'b1, 1'b0);
        end
    endtask

    task automatic test_vblank();
        logic [DW-1:0] exp;
        bus.raw_cut_position = 7;
        bus.descramble = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cycle(DW'(900 + r), 1'b0, 1'b1);
            checks++;
            if (bus.data_out !== DW'(900 + r)) begin
                errors++; $display("FAIL vblank passthrough: got %0d expected %0d", bus.data_out, 900 + r);
            end
            cycle(DW'(950 + r), 1'b1, 1'b1);
            checks += 2;
            if (bus.data_out !== DW'(950 + r)) begin
                errors++; $display("FAIL vblank h word: got %0d expected %0d", bus.data_out, 950 + r);
            end
            if (bus.line_err !== 1'b0) begin
                errors++; $display("FAIL vblank line_err: got %0b expected 0", bus.line_err);
            end
        end
        cycle(10'h200, 1'b1, 1'b0);
        for (int k = 0; k < AW; k++) begin
            cycle(DW'(800 + k), 1'b0, 1'b0);
            exp = DW'(700 + (8 + k) % AW);
            checks++;
            if (bus.data_out !== exp) begin
                errors++; $display("FAIL after vblank word %0d: got %0d expected %0d", k, bus.data_out, exp);
            end
        end
        bus.raw_cut_position = 0;
        bus.descramble = 1'b0;
        bus.enable = 1'b1;
        cycle(10'h3FF, 1'b1, 1'b0);
        cycle(10'h200, 1'b1, 1'b0);
    endtask

    task automatic test_short_line();
        for (int k = 0; k < 10; k++) begin
            cycle(DW'(900 + k), 1'b0, 1'b0);
            checks++;
            if (bus.data_out !== DW'(800 + k)) begin
                errors++; $display("FAIL short line word %0d: got %0d expected %0d", k, bus.data_out, 800 + k);
            end
        end
        cycle(10'h3FF, 1'b1, 1'b0);
        checks++;
        if (bus.line_err !== 1'b1) begin
            errors++; $display("FAIL short line_err pulse: got %0b expected 1", bus.line_err);
        end
        cycle(10'h200, 1'b1, 1'b0);
        checks++;
        if (bus.line_err !== 1'b0) begin
            errors++; $display("FAIL short line_err drop: got %0b expected 0", bus.line_err);
        end
    endtask

    task automatic test_reset_mid_line();
        for (int k = 0; k < 5; k++) cycle(DW'(k), 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL mid reset data_valid: got %0b expected 0", bus.data_valid);
        end
        if (bus.data_out !== '0) begin
            errors++; $display("FAIL mid reset data_out: got %0d expected 0", bus.data_out);
        end
        cycle(DW'(5), 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int k = 6; k < AW + 1; k++) cycle(DW'(k), 1'b0, 1'b0);
        bus.raw_cut_position = 0;
        cycle(10'h3FF, 1'b1, 1'b0);
        checks += 2;
        if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL partial line data_valid: got %0b expected 0", bus.data_valid);
        end
        if (bus.line_err !== 1'b1) begin
            errors++; $display("FAIL partial line line_err: got %0b expected 1", bus.line_err);
        end
        cycle(10'h200, 1'b1, 1'b0);
        for (int k = 0; k < AW; k++) cycle(DW'(100 + k), 1'b0, 1'b0);
        checks++;
        if (bus.data_valid !== 1'b0) begin
            errors++; $display("FAIL full line data_valid early: got %0b expected 0", bus.data_valid);
        end
        cycle(10'h3FF, 1'b1, 1'b0);
        checks += 2;
        if (bus.data_valid !== 1'b1) begin
            errors++; $display("FAIL full line data_valid: got %0b expected 1", bus.data_valid);
        end
        if (bus.line_err !== 1'b0) begin
            errors++; $display("FAIL full line line_err: got %0b expected 0", bus.line_err);
        end
        cycle(10'h200, 1'b1, 1'b0);
        for (int k = 0; k < AW; k++) begin
            cycle(DW'(200 + k), 1'b0, 1'b0);
            checks++;
            if (bus.data_out !== DW'(100 + k)) begin
                errors++; $display("FAIL post reset word %0d: got %0d expected %0d", k, bus.data_out, 100 + k);
            end
        end
    endtask

    initial begin
        bus.data_in = '0;
        bus.H = 1'b1;
        bus.V = 1'b0;
        bus.raw_cut_position = '0;
        bus.descramble = 1'b0;
        bus.enable = 1'b0;
        test_reset();
        test_blank_passthrough();
        test_first_line();
        test_rotations();
        test_vblank();
        test_short_line();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
